sobel_conv_win: RTL and testbench

// - Parametrised successor to the fixed 5x5 Sobel stage of the Canny pipeline.
// - Takes one vertical pixel column per accepted beat from the line buffers.
// - Holds a KxK sliding window and computes signed Gx, Gy and |Gx|+|Gy|, with valid tracking and line-start warm-up.
// - Output feeds non-maximum suppression.

---
 rtl/sobel_conv_win.sv | 199 +++++++++++++++++++
 tb/tb_sobel_conv_win.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_conv_win.sv
// rtl/sobel_conv_win.sv - parametrised KxK Sobel window producing Gx, Gy, |Gx|+|Gy| and direction
// Optional feature: define SOBEL_DIR_EN to build the Canny direction quantiser on dout_dir.
// Ports:
//   clk, rst_b          rising-edge clock, asynchronous active-low reset
//   din_vld, din_sol    column valid, start of line (qualified by din_vld)
//   din                 pixel column, row i (0 = top) at din[(i+1)*DW-1:i*DW]
//   dout_vld            one-cycle strobe, 3 cycles after the window-completing accept
//   dout_gx, dout_gy    saturated signed gradients
//   dout_mag            saturated unsigned |gx|+|gy|
//   dout_dir            direction sector 0..3 (tied to 0 without SOBEL_DIR_EN)
module sobel_conv_win #(
    parameter int K  = 5,
    parameter int DW = 9,
    parameter int OW = 16
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            din_vld,
    input  logic            din_sol,
    input  logic [K*DW-1:0] din,
    output logic            dout_vld,
    output logic [OW-1:0]   dout_gx,
    output logic [OW-1:0]   dout_gy,
    output logic [OW-1:0]   dout_mag,
    output logic [1:0]      dout_dir
);
    // K=5 worst case |G| is 16*3*(2^DW-1), which needs DW+7 signed bits.
    localparam int IW = (K == 5) ? DW + 7 : DW + 4;
    // Headroom for the magnitude sum and for saturation compares against OW limits.
    localparam int EW = ((IW > OW) ? IW : OW) + 2;
    localparam logic signed [EW-1:0] SMAX = (EW'(1) <<< (OW - 1)) - EW'(1);
    localparam logic signed [EW-1:0] SMIN = -SMAX - EW'(1);
    localparam logic signed [EW-1:0] UMAX = (EW'(1) <<< OW) - EW'(1);

    generate
        if (K != 3 && K != 5) begin : g_bad_k
            $error("sobel_conv_win: K must be 3 or 5");
        end
    endgenerate

    function automatic int s_coef(input int idx);
        int c;
        if (K == 3) c = (idx == 1) ? 2 : 1;
        else        c = (idx == 0 || idx == 4) ? 1 : (idx == 2) ? 6 : 4;
        return c;
    endfunction

    function automatic int d_coef(input int idx);
        int c;
        if (K == 3) c = idx - 1;
        else        c = (idx == 0) ? -1 : (idx == 1) ? -2 : (idx == 2) ? 0 : (idx == 3) ? 2 : 1;
        return c;
    endfunction

    logic [DW-1:0]        w [K][K];
    logic [2:0]           ccnt;
    logic                 v0, v1, v2;
    logic signed [IW-1:0] s_sum [K];
    logic signed [IW-1:0] d_sum [K];
    logic signed [IW-1:0] col_s [K];
    logic signed [IW-1:0] col_d [K];
    logic signed [IW-1:0] gx_c, gy_c, gx_r, gy_r;
    logic signed [EW-1:0] gx_e, gy_e, ax, ay, mag_e;
    logic [OW-1:0]        gx_o, gy_o, mag_o;

    // Window and column counter. The window is never cleared on a new line;
    // ccnt alone decides when the stale columns have all been shifted out.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int j = 0; j < K; j++)
                for (int i = 0; i < K; i++)
                    w[j][i] <= '0;
            ccnt <= '0;
            v0   <= 1'b0;
        end else begin
            v0 <= din_vld && !din_sol && (ccnt >= 3'(K - 1));
            if (din_vld) begin
                for (int j = 0; j < K - 1; j++)
                    for (int i = 0; i < K; i++)
                        w[j][i] <= w[j+1][i];
                for (int i = 0; i < K; i++)
                    w[K-1][i] <= din[i*DW +: DW];
                if (din_sol)
                    ccnt <= 3'd1;
                else if (ccnt < 3'(K))
                    ccnt <= ccnt + 3'd1;
            end
        end
    end

    // Per-column vertical smoothing and vertical derivative.
    always_comb begin
        for (int j = 0; j < K; j++) begin
            s_sum[j] = '0;
            d_sum[j] = '0;
            for (int i = 0; i < K; i++) begin
                s_sum[j] = s_sum[j] + IW'(s_coef(i)) * IW'(w[j][i]);
                d_sum[j] = d_sum[j] + IW'(d_coef(i)) * IW'(w[j][i]);
            end
        end
    end

    // Horizontal pass: derivative of smoothed columns gives Gx,
    // smoothing of differentiated columns gives Gy.
    always_comb begin
        gx_c = '0;
        gy_c = '0;
        for (int j = 0; j < K; j++) begin
            gx_c = gx_c + IW'(d_coef(j)) * col_s[j];
            gy_c = gy_c + IW'(s_coef(j)) * col_d[j];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int j = 0; j < K; j++) begin
                col_s[j] <= '0;
                col_d[j] <= '0;
            end
            gx_r <= '0;
            gy_r <= '0;
            v1   <= 1'b0;
            v2   <= 1'b0;
        end else begin
            for (int j = 0; j < K; j++) begin
                col_s[j] <= s_sum[j];
                col_d[j] <= d_sum[j];
            end
            gx_r <= gx_c;
            gy_r <= gy_c;
            v1   <= v0;
            v2   <= v1;
        end
    end

    // Magnitude is formed from the unsaturated gradients, then clipped.
    always_comb begin
        gx_e  = EW'(gx_r);
        gy_e  = EW'(gy_r);
        ax    = gx_e[EW-1] ? -gx_e : gx_e;
        ay    = gy_e[EW-1] ? -gy_e : gy_e;
        mag_e = ax + ay;
        if (gx_e > SMAX)      gx_o = SMAX[OW-1:0];
        else if (gx_e < SMIN) gx_o = SMIN[OW-1:0];
        else                  gx_o = gx_e[OW-1:0];
        if (gy_e > SMAX)      gy_o = SMAX[OW-1:0];
        else if (gy_e < SMIN) gy_o = SMIN[OW-1:0];
        else                  gy_o = gy_e[OW-1:0];
        if (mag_e > UMAX)     mag_o = UMAX[OW-1:0];
        else                  mag_o = mag_e[OW-1:0];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            dout_vld <= 1'b0;
            dout_gx  <= '0;
            dout_gy  <= '0;
            dout_mag <= '0;
        end else begin
            dout_vld <= v2;
            if (v2) begin
                dout_gx  <= gx_o;
                dout_gy  <= gy_o;
                dout_mag <= mag_o;
            end
        end
    end

`ifdef SOBEL_DIR_EN
    logic [EW+5:0] ax_l, ay_l;
    logic [1:0]    dir_o;

    // 13/32 approximates tan(22.5 deg) for the sector boundaries.
    always_comb begin
        ax_l = (EW+6)'(ax);
        ay_l = (EW+6)'(ay);
        if (gx_r == '0 && gy_r == '0)
            dir_o = 2'd0;
        else if ((ay_l << 5) < ax_l * (EW+6)'(13))
            dir_o = 2'd0;
        else if ((ax_l << 5) < ay_l * (EW+6)'(13))
            dir_o = 2'd2;
        else if (gx_r[IW-1] == gy_r[IW-1])
            dir_o = 2'd1;
        else
            dir_o = 2'd3;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            dout_dir <= 2'd0;
        else if (v2)
            dout_dir <= dir_o;
    end
`else
    assign dout_dir = 2'b00;
`endif

endmodule

// File: tb/tb_sobel_conv_win.sv
// tb/tb_sobel_conv_win.sv - directed self-checking bench for sobel_conv_win
module tb_sobel_conv_win;
    logic        clk = 1'b0;
    logic        rst_b;
    logic        vld3, sol3, vld5, sol5;
    logic [26:0] din3;
    logic [44:0] din5;
    logic        ov3, ov5, ovs;
    logic [15:0] gx3, gy3, mag3, gx5, gy5, mag5;
    logic [11:0] gxs, gys, mags;
    logic [1:0]  dir3, dir5, dirs;

    always #5 clk = ~clk;

    sobel_conv_win #(.K(3), .DW(9), .OW(16)) u3 (
        .clk(clk), .rst_b(rst_b), .din_vld(vld3), .din_sol(sol3), .din(din3),
        .dout_vld(ov3), .dout_gx(gx3), .dout_gy(gy3), .dout_mag(mag3), .dout_dir(dir3));
    sobel_conv_win #(.K(5), .DW(9), .OW(16)) u5 (
        .clk(clk), .rst_b(rst_b), .din_vld(vld5), .din_sol(sol5), .din(din5),
        .dout_vld(ov5), .dout_gx(gx5), .dout_gy(gy5), .dout_mag(mag5), .dout_dir(dir5));
    sobel_conv_win #(.K(5), .DW(9), .OW(12)) u5s (
        .clk(clk), .rst_b(rst_b), .din_vld(vld5), .din_sol(sol5), .din(din5),
        .dout_vld(ovs), .dout_gx(gxs), .dout_gy(gys), .dout_mag(mags), .dout_dir(dirs));

    typedef struct {
        int cv[5];
        int rv[5];
        int gx, gy, mag, dir;
        int sgx, sgy, smag;
    } vec_t;

    vec_t vt[11];
    int n_err = 0, n_chk = 0;
    int cyc = 0, p3 = 0, p5 = 0, ps = 0, first3 = -1, last5 = -1, nz3 = 0, acc = 0;

    function automatic vec_t mk(int c0, int c1, int c2, int c3, int c4,
                                int r0, int r1, int r2, int r3, int r4,
                                int gx, int gy, int mag, int dir, int sgx, int sgy, int smag);
        vec_t v;
        v.cv[0] = c0; v.cv[1] = c1; v.cv[2] = c2; v.cv[3] = c3; v.cv[4] = c4;
        v.rv[0] = r0; v.rv[1] = r1; v.rv[2] = r2; v.rv[3] = r3; v.rv[4] = r4;
        v.gx = gx; v.gy = gy; v.mag = mag; v.dir = dir;
        v.sgx = sgx; v.sgy = sgy; v.smag = smag;
        return v;
    endfunction

    function automatic logic [44:0] col5(input int k, input int j);
        logic [44:0] d;
        for (int i = 0; i < 5; i++) d[i*9 +: 9] = 9'(vt[k].cv[j] + vt[k].rv[i]);
        return d;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (ov3) begin
            p3++;
            if (first3 < 0) first3 = cyc;
            if (gx3 != 0 || gy3 != 0 || mag3 != 0) nz3++;
        end
        if (ov5) begin
            p5++;
            last5 = cyc;
        end
        if (ovs) ps++;
    endtask

    task automatic drive5(input logic v, input logic s, input logic [44:0] d);
        vld5 = v; sol5 = s; din5 = d;
        tick;
    endtask

    task automatic drive3(input logic v, input logic s, input logic [26:0] d);
        vld3 = v; sol3 = s; din3 = d;
        tick;
    endtask

    task automatic check5(input string tag, input int k);
        check({tag, "_gx"},  k, int'($signed(gx5)), vt[k].gx);
        check({tag, "_gy"},  k, int'($signed(gy5)), vt[k].gy);
        check({tag, "_mag"}, k, int'(mag5), vt[k].mag);
`ifdef SOBEL_DIR_EN
        check({tag, "_dir"}, k, int'(dir5), vt[k].dir);
`else
        check({tag, "_dir"}, k, int'(dir5), 0);
`endif
    endtask

    initial begin
        vt[0]  = mk(  0,  0,  0,  0,  0,    0, 0, 0,  0,  0,       0,     0,     0, 0,     0,     0,    0);
        vt[1]  = mk(  0,  0,  0,511,511,    0, 0, 0,  0,  0,   24528,     0, 24528, 0,  2047,     0, 4095);
        vt[2]  = mk(  0,  0,  0,  0,  0,    0, 0, 0,511,511,       0, 24528, 24528, 2,     0,  2047, 4095);
        vt[3]  = mk(511,511,  0,  0,  0,    0, 0, 0,  0,  0,  -24528,     0, 24528, 0, -2048,     0, 4095);
        vt[4]  = mk(  0,  0,  0,  0,100,    0, 0, 0,  0,  0,    1600,     0,  1600, 0,  1600,     0, 1600);
        vt[5]  = mk( 10, 20, 30, 40, 50,    5, 0, 0,  0,  0,    1280,   -80,  1360, 0,  1280,   -80, 1360);
        vt[6]  = mk(200,  0,  0,  0,  0,    0, 0, 0,  0,300,   -3200,  4800,  8000, 3, -2048,  2047, 4095);
        vt[7]  = mk(  0,  0,  0,  0,200,    0, 0, 0,  0,300,    3200,  4800,  8000, 1,  2047,  2047, 4095);
        vt[8]  = mk(  0,  0,  0,  0,255,    0, 0, 0,  0,256,    4080,  4096,  8176, 1,  2047,  2047, 4095);
        vt[9]  = mk(255,  0,  0,  0,  0,    0, 0, 0,  0,256,   -4080,  4096,  8176, 3, -2048,  2047, 4095);
        vt[10] = mk(  0,  0,  0,  0,  0,  300, 0, 0,  0,  0,       0, -4800,  4800, 2,     0, -2048, 4095);

        rst_b = 1'b0;
        vld3 = 1'b0; sol3 = 1'b0; din3 = '0;
        vld5 = 1'b0; sol5 = 1'b0; din5 = '0;
        repeat (3) tick;
        check("rst_vld3", 0, int'(ov3), 0);
        check("rst_vld5", 0, int'(ov5), 0);
        check("rst_gx5",  0, int'(gx5), 0);
        check("rst_mags", 0, int'(mags), 0);
        rst_b = 1'b1;
        repeat (2) tick;

        // Table: one fresh line per vector, K=5 at OW=16 and OW=12 in parallel.
        for (int k = 0; k < 11; k++) begin
            p5 = 0; ps = 0; last5 = -1;
            for (int j = 0; j < 5; j++) drive5(1'b1, j == 0, col5(k, j));
            acc = cyc;
            vld5 = 1'b0; sol5 = 1'b0;
            repeat (6) tick;
            check("vec_pulses", k, p5, 1);
            check("vec_pulses_sat", k, ps, 1);
            check("vec_latency", k, last5 - acc, 3);
            check5("vec", k);
            check("vec_sat_gx",  k, int'($signed(gxs)), vt[k].sgx);
            check("vec_sat_gy",  k, int'($signed(gys)), vt[k].sgy);
            check("vec_sat_mag", k, int'(mags), vt[k].smag);
        end

        // K=3 flat field: 6 columns give 4 back-to-back zero results.
        p3 = 0; first3 = -1; nz3 = 0;
        for (int j = 0; j < 6; j++) begin
            drive3(1'b1, j == 0, {3{9'd100}});
            if (j == 2) acc = cyc;
        end
        vld3 = 1'b0; sol3 = 1'b0;
        repeat (5) tick;
        check("flat_pulses", 0, p3, 4);
        check("flat_latency", 0, first3 - acc, 3);
        check("flat_nonzero", 0, nz3, 0);

        // K=3 vertical step 0,0,511.
        p3 = 0; first3 = -1;
        drive3(1'b1, 1'b1, '0);
        drive3(1'b1, 1'b0, '0);
        drive3(1'b1, 1'b0, {3{9'd511}});
        acc = cyc;
        vld3 = 1'b0; sol3 = 1'b0;
        repeat (5) tick;
        check("vstep3_pulses", 0, p3, 1);
        check("vstep3_latency", 0, first3 - acc, 3);
        check("vstep3_gx", 0, int'($signed(gx3)), 2044);
        check("vstep3_gy", 0, int'($signed(gy3)), 0);
        check("vstep3_mag", 0, int'(mag3), 2044);
        check("vstep3_dir", 0, int'(dir3), 0);

        // K=5 line restart with gaps; bubbles carry din_sol=1 which must be ignored.
        p5 = 0; last5 = -1;
        drive5(1'b1, 1'b1, '1);
        drive5(1'b1, 1'b0, '1);
        for (int j = 0; j < 5; j++) begin
            drive5(1'b1, j == 0, col5(5, j));
            if (j == 4) acc = cyc;
            else drive5(1'b0, 1'b1, '1);
        end
        vld5 = 1'b0; sol5 = 1'b0;
        repeat (6) tick;
        check("gap_pulses", 5, p5, 1);
        check("gap_latency", 5, last5 - acc, 3);
        check5("gap", 5);

        // Reset while results are in flight.
        p5 = 0;
        for (int j = 0; j < 7; j++) drive5(1'b1, j == 0, col5(1, j < 5 ? j : 4));
        drive5(1'b0, 1'b0, '0);
        check("pre_rst_vld", 1, int'(ov5), 1);
        check("pre_rst_gx", 1, int'($signed(gx5)), 24528);
        rst_b = 1'b0;
        #1;
        check("mid_rst_vld", 1, int'(ov5), 0);
        check("mid_rst_gx",  1, int'(gx5), 0);
        check("mid_rst_gy",  1, int'(gy5), 0);
        check("mid_rst_mag", 1, int'(mag5), 0);
        check("mid_rst_dir", 1, int'(dir5), 0);
        check("mid_rst_sat_mag", 1, int'(mags), 0);
        repeat (2) tick;
        rst_b = 1'b1;
        p5 = 0;
        repeat (6) tick;
        check("post_rst_stale", 1, p5, 0);
        // Column counter restarts from 0: five accepts without din_sol complete a window.
        p5 = 0; last5 = -1;
        for (int j = 0; j < 5; j++) drive5(1'b1, 1'b0, col5(1, j));
        acc = cyc;
        vld5 = 1'b0;
        repeat (6) tick;
        check("post_rst_pulses", 1, p5, 1);
        check("post_rst_latency", 1, last5 - acc, 3);
        check5("post_rst", 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
